// File: rtl/panel_input_conditioner_if.sv
// Panel I/O bundle: raw buttons/switches in, conditioned pulses and switch value out.
// The master drives the raw inputs; the slave (conditioner) drives the conditioned outputs.
interface panel_input_conditioner_if #(
    parameter int SWITCH_WIDTH = 4
);
    logic                    btnExec;
    logic                    btnReset;
    logic [SWITCH_WIDTH-1:0] switches;
    logic                    execPulse;
    logic                    resetPulse;
    logic [SWITCH_WIDTH-1:0] inValue;
    logic                    inChanged;

    modport master (
        output btnExec, btnReset, switches,
        input  execPulse, resetPulse, inValue, inChanged
    );

    modport slave (
        input  btnExec, btnReset, switches,
        output execPulse, resetPulse, inValue, inChanged
    );
endinterface

// File: rtl/panel_input_conditioner.sv
// Synchronises and debounces the panel buttons and switches, producing registered
// exec/reset pulses and a stable switch word for the processor controller.
module panel_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int SYNC_STAGES     = 2,
    parameter int SWITCH_WIDTH    = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    panel_input_conditioner_if.slave  pif
);

    localparam int RAW_W = SWITCH_WIDTH + 2;
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int BTN_EXEC  = 0;
    localparam int BTN_RESET = 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS_CNT = 2'd1,
        HELD      = 2'd2,
        REL_CNT   = 2'd3
    } btn_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == LAST) ? c : c + CNT_W'(1);
    endfunction

    // Synchroniser chains, one bit per raw input: {switches, btnReset, btnExec}
    logic [SYNC_STAGES-1:0][RAW_W-1:0] sync_q, sync_d;
    logic [RAW_W-1:0]                  s_word;
    logic [1:0]                        s_btn;
    logic [SWITCH_WIDTH-1:0]           s_sw;

    always_comb begin
        sync_d[0] = {pif.switches, pif.btnReset, pif.btnExec};
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    assign s_word = sync_q[SYNC_STAGES-1];
    assign s_btn  = s_word[1:0];
    assign s_sw   = s_word[RAW_W-1:2];

    // Button FSMs: state register / next-state / output processes
    btn_state_e       state_q [2];
    btn_state_e       state_d [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [1:0]       qual;
    logic             exec_pulse_q, exec_pulse_d;
    logic             reset_pulse_q, reset_pulse_d;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (s_btn[i]) begin
                        state_d[i] = PRESS_CNT;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_CNT: begin
                    if (!s_btn[i]) begin
                        state_d[i] = IDLE;
                    end else if (cnt_q[i] == LAST) begin
                        state_d[i] = HELD;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
                HELD: begin
                    if (!s_btn[i]) begin
                        state_d[i] = REL_CNT;
                        cnt_d[i]   = '0;
                    end
                end
                REL_CNT: begin
                    if (s_btn[i]) begin
                        state_d[i] = HELD;
                    end else if (cnt_q[i] == LAST) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = sat_inc(cnt_q[i]);
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // A press qualifies on the PRESS_CNT -> HELD transition; reset wins a tie
    always_comb begin
        qual = '0;
        for (int i = 0; i < 2; i++) begin
            qual[i] = (state_q[i] == PRESS_CNT) && s_btn[i] && (cnt_q[i] == LAST);
        end
        reset_pulse_d = qual[BTN_RESET];
        exec_pulse_d  = qual[BTN_EXEC] && !qual[BTN_RESET];
    end

    // Switch word debounce with a single shared stability counter
    logic [SWITCH_WIDTH-1:0] sw_prev_q, sw_prev_d;
    logic [CNT_W-1:0]        sw_cnt_q, sw_cnt_d;
    logic [SWITCH_WIDTH-1:0] in_value_q, in_value_d;
    logic                    in_changed_q, in_changed_d;
    logic                    sw_stable;
    logic                    sw_commit;

    always_comb begin
        sw_stable    = (s_sw == sw_prev_q);
        sw_prev_d    = s_sw;
        sw_cnt_d     = sw_stable ? sat_inc(sw_cnt_q) : '0;
        sw_commit    = sw_stable && (sw_cnt_q == LAST) && (s_sw != in_value_q);
        in_value_d   = sw_commit ? s_sw : in_value_q;
        in_changed_d = sw_commit;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q        <= '0;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            exec_pulse_q  <= 1'b0;
            reset_pulse_q <= 1'b0;
            sw_prev_q     <= '0;
            sw_cnt_q      <= '0;
            in_value_q    <= '0;
            in_changed_q  <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            exec_pulse_q  <= exec_pulse_d;
            reset_pulse_q <= reset_pulse_d;
            sw_prev_q     <= sw_prev_d;
            sw_cnt_q      <= sw_cnt_d;
            in_value_q    <= in_value_d;
            in_changed_q  <= in_changed_d;
        end
    end

    assign pif.execPulse  = exec_pulse_q;
    assign pif.resetPulse = reset_pulse_q;
    assign pif.inValue    = in_value_q;
    assign pif.inChanged  = in_changed_q;

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Scoreboard bench for panel_input_conditioner: a run-length reference model predicts
// every pulse and switch update; a negedge monitor matches them against the DUT outputs.
module tb_panel_input_conditioner;

    localparam int D = 4;
    localparam int S = 2;
    localparam int W = 4;

    typedef struct {
        int           cyc;
        logic [W-1:0] val;
    } sw_ev_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    panel_input_conditioner_if #(.SWITCH_WIDTH(W)) pif ();

    panel_input_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S),
        .SWITCH_WIDTH   (W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .pif  (pif)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int     exp_exec_q [$];
    int     exp_rst_q  [$];
    sw_ev_t exp_sw_q   [$];

    // Reference model state: synced sample delay line, debounced levels, run lengths
    logic [W+1:0] sp [S];
    logic         db [2];
    int           run [2];
    logic [W-1:0] sw_word;
    int           sw_run;
    logic [W-1:0] m_inval;

    int exec_seen = 0, rst_seen = 0, chg_seen = 0;
    int last_exec = -1, last_rst = -1;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_unexpected(input string name);
        total++;
        bad++;
        $display("FAIL %s: got pulse expected none (cycle %0d)", name, cyc);
    endtask

    // Model: a level flips once it has disagreed with the debounced level for D+1 samples;
    // the switch word commits once it has been seen for D+1 consecutive samples.
    always @(posedge clock) begin
        logic [W+1:0] s;
        logic [W-1:0] sw;
        logic         press [2];
        cyc++;
        if (reset) begin
            for (int k = 0; k < S; k++) sp[k] = '0;
            for (int i = 0; i < 2; i++) begin
                db[i]  = 1'b0;
                run[i] = 0;
            end
            sw_word = '0;
            sw_run  = 1;
            m_inval = '0;
        end else begin
            s = sp[S-1];
            for (int k = S-1; k > 0; k--) sp[k] = sp[k-1];
            sp[0] = {pif.switches, pif.btnReset, pif.btnExec};
            for (int i = 0; i < 2; i++) begin
                press[i] = 1'b0;
                if (s[i] == db[i]) begin
                    run[i] = 0;
                end else begin
                    run[i]++;
                    if (run[i] == D + 1) begin
                        db[i]    = s[i];
                        run[i]   = 0;
                        press[i] = s[i];
                    end
                end
            end
            if (press[1]) exp_rst_q.push_back(cyc);
            else if (press[0]) exp_exec_q.push_back(cyc);
            sw = s[W+1:2];
            if (sw == sw_word) begin
                sw_run++;
            end else begin
                sw_word = sw;
                sw_run  = 1;
            end
            if (sw_run >= D + 1 && sw != m_inval) begin
                m_inval = sw;
                exp_sw_q.push_back('{cyc, sw});
            end
        end
    end

    // Monitor
    always @(negedge clock) begin
        if (mon_en) begin
            if (pif.execPulse === 1'b1) begin
                exec_seen++;
                last_exec = cyc;
                if (exp_exec_q.size() == 0) chk_unexpected("exec_pulse");
                else chk("exec_pulse_cycle", cyc, exp_exec_q.pop_front());
            end else if (pif.execPulse !== 1'b0) begin
                chk("exec_pulse_known", 0, 1);
            end
            if (pif.resetPulse === 1'b1) begin
                rst_seen++;
                last_rst = cyc;
                if (exp_rst_q.size() == 0) chk_unexpected("reset_pulse");
                else chk("reset_pulse_cycle", cyc, exp_rst_q.pop_front());
            end else if (pif.resetPulse !== 1'b0) begin
                chk("reset_pulse_known", 0, 1);
            end
            if (pif.inChanged === 1'b1) begin
                sw_ev_t e;
                chg_seen++;
                if (exp_sw_q.size() == 0) begin
                    chk_unexpected("in_changed");
                end else begin
                    e = exp_sw_q.pop_front();
                    chk("in_changed_cycle", cyc, e.cyc);
                    chk("in_changed_value", int'(pif.inValue), int'(e.val));
                end
            end
            chk("in_value", int'(pif.inValue), int'(m_inval));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        int base, e0, r0, c0, hold;
        reset        = 1'b1;
        pif.btnExec  = 1'b0;
        pif.btnReset = 1'b0;
        pif.switches = '0;
        cycles(2);
        chk("rst_execPulse",  int'(pif.execPulse),  0);
        chk("rst_resetPulse", int'(pif.resetPulse), 0);
        chk("rst_inValue",    int'(pif.inValue),    0);
        chk("rst_inChanged",  int'(pif.inChanged),  0);
        mon_en = 1'b1;
        reset  = 1'b0;
        cycles(3);

        // Single held press
        base = cyc; e0 = exec_seen; r0 = rst_seen;
        pif.btnExec = 1'b1;
        cycles(20);
        chk("t1_exec_count", exec_seen - e0, 1);
        chk("t1_exec_edge",  last_exec, base + 7);
        chk("t1_rst_count",  rst_seen - r0, 0);
        pif.btnExec = 1'b0;
        cycles(12);

        // Fast toggling never qualifies
        e0 = exec_seen;
        for (int i = 0; i < 8; i++) begin
            pif.btnExec = ~i[0];
            cycles(2);
        end
        pif.btnExec = 1'b0;
        cycles(10);
        chk("t2_exec_count", exec_seen - e0, 0);

        // Simultaneous qualification: reset wins, exec pulse is lost
        base = cyc; e0 = exec_seen; r0 = rst_seen;
        pif.btnExec  = 1'b1;
        pif.btnReset = 1'b1;
        cycles(10);
        chk("t3_rst_count",  rst_seen - r0, 1);
        chk("t3_rst_edge",   last_rst, base + 7);
        chk("t3_exec_count", exec_seen - e0, 0);
        pif.btnExec  = 1'b0;
        pif.btnReset = 1'b0;
        cycles(10);
        pif.btnExec = 1'b1;
        cycles(10);
        chk("t3_exec_again", exec_seen - e0, 1);
        pif.btnExec = 1'b0;
        cycles(10);

        // Release bounce must not re-pulse
        e0 = exec_seen;
        pif.btnExec = 1'b1; cycles(10);
        pif.btnExec = 1'b0; cycles(1);
        pif.btnExec = 1'b1; cycles(1);
        pif.btnExec = 1'b0; cycles(12);
        chk("t4_exec_count", exec_seen - e0, 1);

        // Switch word qualification and a short flicker
        c0 = chg_seen;
        pif.switches = 4'hA; cycles(10);
        chk("t5_inValue_A",  int'(pif.inValue), 'hA);
        chk("t5_chg_count",  chg_seen - c0, 1);
        c0 = chg_seen;
        pif.switches = 4'h5; cycles(2);
        pif.switches = 4'hA; cycles(10);
        chk("t5_inValue_hold", int'(pif.inValue), 'hA);
        chk("t5_chg_flicker",  chg_seen - c0, 0);

        // Reset mid-debounce, button held through reset release
        base = cyc; r0 = rst_seen;
        pif.btnReset = 1'b1;
        cycles(5);
        reset = 1'b1;
        cycles(1);
        chk("t6_abort_count", rst_seen - r0, 0);
        chk("t6_inValue_0",   int'(pif.inValue), 0);
        reset = 1'b0;
        cycles(12);
        chk("t6_rst_count", rst_seen - r0, 1);
        chk("t6_rst_edge",  last_rst, base + 6 + 7);
        pif.btnReset = 1'b0;
        cycles(15);

        // Randomised levels and hold times, occasional reset
        for (int n = 0; n < 300; n++) begin
            pif.btnExec  = 1'($urandom_range(0, 1));
            pif.btnReset = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) pif.switches = W'($urandom);
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(6, 12))
                                               : int'($urandom_range(1, 4));
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                cycles(1);
                reset = 1'b0;
            end
            cycles(hold);
        end
        pif.btnExec  = 1'b0;
        pif.btnReset = 1'b0;
        cycles(20);
        chk("drain_exec_q", exp_exec_q.size(), 0);
        chk("drain_rst_q",  exp_rst_q.size(),  0);
        chk("drain_sw_q",   exp_sw_q.size(),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
